skip_seq_counter: RTL and testbench

//  Parametrised synchronous sequence counter. It steps through every WIDTH-bit state

---
 rtl/skip_seq_counter.sv | 101 ++++++++++
 tb/tb_skip_seq_counter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/skip_seq_counter.sv
// ============================================================================
// Module   : skip_seq_counter
// Purpose  : Up/down sequence counter that skips states flagged in SKIP_MASK
//            and recovers from them on its own. The optional gray_o output is
//            enabled by defining SKIP_SEQ_GRAY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module skip_seq_counter #(
    parameter int                    WIDTH     = 3,
    parameter logic [2**WIDTH-1:0]   SKIP_MASK = 8'h88,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             illegal_o
`ifdef SKIP_SEQ_GRAY_EN
    ,
    output logic [WIDTH-1:0] gray_o
`endif
);

    localparam int c_NSTATES = 2**WIDTH;

    if ((SKIP_MASK == {c_NSTATES{1'b1}}) || SKIP_MASK[RESET_VAL]) begin : g_bad_params
        $error("skip_seq_counter: SKIP_MASK has no valid state or RESET_VAL is skipped");
    end

    // Nearest non-skipped state in the chosen direction. If no other state is
    // valid, the current state is returned, so a lone valid state wraps to itself.
    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] cur,
                                                input logic             up);
        logic [WIDTH-1:0] cand;
        logic [WIDTH-1:0] res;
        logic             found;
        cand  = cur;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i < c_NSTATES; i++) begin
            cand = up ? cand + 1'b1 : cand - 1'b1;
            if (!found && !SKIP_MASK[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    always_comb begin
        w_step = f_step(r_count, dir);
        w_wrap = dir ? (w_step <= r_count) : (w_step >= r_count);
        w_next = r_count;
        if (load) begin
            w_next = load_val;
        end else if (en) begin
            w_next = w_step;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= RESET_VAL;
        end else begin
            r_count <= w_next;
        end
    end

    assign count_o   = r_count;
    // Gated by reset so tc_o stays low while the counter is held.
    assign tc_o      = reset & en & ~load & w_wrap;
    assign illegal_o = SKIP_MASK[r_count];

`ifdef SKIP_SEQ_GRAY_EN
    logic [WIDTH-1:0] r_gray;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gray <= RESET_VAL ^ (RESET_VAL >> 1);
        end else begin
            r_gray <= w_next ^ (w_next >> 1);
        end
    end

    assign gray_o = r_gray;
`endif

endmodule

`default_nettype wire

// File: tb/tb_skip_seq_counter.sv
// Directed bench for skip_seq_counter; expected counts are queued at drive time
// and compared when the registered output appears.
`default_nettype none

module tb_skip_seq_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic       load = 1'b0;
    logic [2:0] load_val = '0;

    logic [2:0] count0;
    logic       tc0;
    logic       illegal0;
    logic [3:0] count1;
    logic       tc1;
    logic       illegal1;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef SKIP_SEQ_GRAY_EN
    logic [2:0] gray0;
    logic [3:0] gray1;
    logic [2:0] count2;
    logic       tc2;
    logic       illegal2;
    logic [2:0] gray2;
    logic       en2 = 1'b0;
`endif

    skip_seq_counter #(.WIDTH(3), .SKIP_MASK(8'h88), .RESET_VAL(3'd0)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .count_o(count0), .tc_o(tc0), .illegal_o(illegal0)
`ifdef SKIP_SEQ_GRAY_EN
        , .gray_o(gray0)
`endif
    );

    skip_seq_counter #(.WIDTH(4), .SKIP_MASK(16'hFFFE), .RESET_VAL(4'd0)) dut_single (
        .clk(clk), .reset(reset), .en(1'b1), .dir(dir), .load(1'b0),
        .load_val(4'd0), .count_o(count1), .tc_o(tc1), .illegal_o(illegal1)
`ifdef SKIP_SEQ_GRAY_EN
        , .gray_o(gray1)
`endif
    );

`ifdef SKIP_SEQ_GRAY_EN
    skip_seq_counter #(.WIDTH(3), .SKIP_MASK(8'h00), .RESET_VAL(3'd0)) dut_gray (
        .clk(clk), .reset(reset), .en(en2), .dir(1'b1), .load(1'b0),
        .load_val(3'd0), .count_o(count2), .tc_o(tc2), .illegal_o(illegal2),
        .gray_o(gray2)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check tc_o before the edge, count_o after it.
    task automatic cyc(input logic e, input logic d, input logic l, input logic [2:0] lv,
                       input logic exp_tc, input logic [2:0] exp_next, input string tag);
        @(negedge clk);
        en = e; dir = d; load = l; load_val = lv;
        #1;
        chk({tag, "_tc"}, 32'(tc0), 32'(exp_tc));
        exp_q.push_back(exp_next);
        @(posedge clk);
        #1;
        chk({tag, "_cnt"}, 32'(count0), 32'(exp_q.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with en=1 dir=0 to show tc_o is held low in reset
        en = 1'b1; dir = 1'b0;
        #23;
        chk("rst_cnt", 32'(count0), 32'd0);
        chk("rst_tc", 32'(tc0), 32'd0);
        chk("rst_illegal", 32'(illegal0), 32'd0);
        chk("rst_single_tc", 32'(tc1), 32'd0);
        @(negedge clk);
        en = 1'b0; dir = 1'b1;
        reset = 1'b1;

        // Count up: 0,1,2,4,5,6,0,1
        cyc(1, 1, 0, 0, 0, 3'd1, "up0");
        cyc(1, 1, 0, 0, 0, 3'd2, "up1");
        cyc(1, 1, 0, 0, 0, 3'd4, "up2");
        cyc(1, 1, 0, 0, 0, 3'd5, "up4");
        cyc(1, 1, 0, 0, 0, 3'd6, "up5");
        cyc(1, 1, 0, 0, 1, 3'd0, "up6");
        cyc(1, 1, 0, 0, 0, 3'd1, "up0b");
        cyc(0, 1, 0, 0, 0, 3'd1, "hold");

        // Back to 0, then count down: 6,5,4,2,1,0,6
        cyc(0, 1, 1, 3'd0, 0, 3'd0, "ld0");
        cyc(1, 0, 0, 0, 1, 3'd6, "dn0");
        cyc(1, 0, 0, 0, 0, 3'd5, "dn6");
        cyc(1, 0, 0, 0, 0, 3'd4, "dn5");
        cyc(1, 0, 0, 0, 0, 3'd2, "dn4");
        cyc(1, 0, 0, 0, 0, 3'd1, "dn2");
        cyc(1, 0, 0, 0, 0, 3'd0, "dn1");
        cyc(1, 0, 0, 0, 1, 3'd6, "dn0b");

        // Load skipped states and self-correct
        cyc(0, 1, 1, 3'd7, 0, 3'd7, "ld7");
        chk("ill7", 32'(illegal0), 32'd1);
        cyc(1, 1, 0, 0, 1, 3'd0, "fix7up");
        chk("ill0", 32'(illegal0), 32'd0);
        cyc(0, 0, 1, 3'd3, 0, 3'd3, "ld3");
        chk("ill3", 32'(illegal0), 32'd1);
        cyc(1, 0, 0, 0, 0, 3'd2, "fix3dn");
        chk("ill2", 32'(illegal0), 32'd0);

        // Load has priority over en; tc_o suppressed
        cyc(1, 1, 1, 3'd5, 0, 3'd5, "ldpri");

        // Asynchronous reset mid-cycle
        #3;
        reset = 1'b0;
        #1;
        chk("arst_cnt", 32'(count0), 32'd0);
        chk("arst_ill", 32'(illegal0), 32'd0);
        @(negedge clk);
        en = 1'b1; dir = 1'b1; load = 1'b0;
        #1;
        chk("arst_tc", 32'(tc0), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold", 32'(count0), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(3'd1);
        @(posedge clk);
        #1;
        chk("arst_resume", 32'(count0), 32'(exp_q.pop_front()));

        // Single valid state instance: stays 0, tc_o every cycle
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dir = k[0];
            #1;
            chk("single_cnt", 32'(count1), 32'd0);
            chk("single_tc", 32'(tc1), 32'd1);
        end

`ifdef SKIP_SEQ_GRAY_EN
        begin
            logic [2:0] gexp [8];
            gexp = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
            @(negedge clk);
            reset = 1'b0;
            en2 = 1'b1;
            #1;
            chk("gray_rst", 32'(gray2), 32'd0);
            @(negedge clk);
            reset = 1'b1;
            for (int k = 0; k < 8; k++) begin
                #1;
                chk("gray_seq", 32'(gray2), 32'(gexp[k]));
                @(negedge clk);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
